// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: feeds two wide operands one nibble per clock (LS first) into an
// external combinational 4-bit adder and chains its carry, presenting a registered wide
// result with a one-cycle DONE pulse.
// Optional feature macro: SUB_EN adds the SUB port (A - B via inverted B and carry-in 1).
module nibble_serial_adder #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   START,
`ifdef SUB_EN
    input  logic                   SUB,
`endif
    input  logic [4*NIBBLES-1:0]   OP_A,
    input  logic [4*NIBBLES-1:0]   OP_B,
    input  logic                   CIN,
    output logic                   BUSY,
    output logic                   DONE,
    output logic [4*NIBBLES-1:0]   SUM,
    output logic                   COUT,
    output logic                   OVF,
    output logic [3:0]             ADD_A,
    output logic [3:0]             ADD_B,
    output logic                   ADD_CIN,
    input  logic [3:0]             ADD_S,
    input  logic                   ADD_COUT
);

    localparam int unsigned W    = 4 * NIBBLES;
    localparam int unsigned IdxW = $clog2(NIBBLES);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [W-1:0]      a_sh_q, a_sh_d;
    logic [W-1:0]      b_sh_q, b_sh_d;
    // Holds the nibbles already produced; the newest nibble is appended on top each cycle.
    logic [W-5:0]      work_q, work_d;
    logic              carry_q, carry_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic              a_sign_q, a_sign_d;
    logic              b_sign_q, b_sign_d;
    logic [W-1:0]      sum_q, sum_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;

    logic [W-1:0]      b_eff;
    logic              cin_eff;
    logic [W-1:0]      work_full;

    // Effective B operand and initial carry chosen at START.
    always_comb begin
`ifdef SUB_EN
        b_eff   = SUB ? ~OP_B : OP_B;
        cin_eff = SUB ? 1'b1 : CIN;
`else
        b_eff   = OP_B;
        cin_eff = CIN;
`endif
    end

    assign work_full = {ADD_S, work_q};

    // Next-state logic: operand load, per-nibble shift, and result capture on the last nibble.
    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        work_d   = work_q;
        carry_d  = carry_q;
        idx_d    = idx_q;
        a_sign_d = a_sign_q;
        b_sign_d = b_sign_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (START) begin
                    a_sh_d   = OP_A;
                    b_sh_d   = b_eff;
                    carry_d  = cin_eff;
                    idx_d    = '0;
                    a_sign_d = OP_A[W-1];
                    b_sign_d = b_eff[W-1];
                    state_d  = StRun;
                end else begin
                    state_d  = StIdle;
                end
            end
            StRun: begin
                a_sh_d  = a_sh_q >> 4;
                b_sh_d  = b_sh_q >> 4;
                work_d  = work_full[W-1:4];
                carry_d = ADD_COUT;
                idx_d   = idx_q + IdxW'(1);
                if (idx_q == IdxW'(NIBBLES - 1)) begin
                    sum_d   = work_full;
                    cout_d  = ADD_COUT;
                    ovf_d   = (a_sign_q == b_sign_q) && (ADD_S[3] != a_sign_q);
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q  <= StIdle;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            work_q   <= '0;
            carry_q  <= 1'b0;
            idx_q    <= '0;
            a_sign_q <= 1'b0;
            b_sign_q <= 1'b0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            work_q   <= work_d;
            carry_q  <= carry_d;
            idx_q    <= idx_d;
            a_sign_q <= a_sign_d;
            b_sign_q <= b_sign_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    // Outputs: adder drive only while running, status from state, result registers.
    always_comb begin
        BUSY    = (state_q == StRun);
        DONE    = (state_q == StDone);
        ADD_A   = BUSY ? a_sh_q[3:0] : 4'h0;
        ADD_B   = BUSY ? b_sh_q[3:0] : 4'h0;
        ADD_CIN = BUSY ? carry_q : 1'b0;
        SUM     = sum_q;
        COUT    = cout_q;
        OVF     = ovf_q;
    end

endmodule
